// File: rtl/fcvt_int_pipe.sv
// FP-to-integer back end: classifies the operand, saturates per RISC-V rules and
// returns result/fflags through a two-stage valid/ready pipeline with flush.
module fcvt_int_pipe #(
    parameter int W  = 32,
    parameter int TW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_fp,
    input  logic [W-1:0]  in_trunc,
    input  logic          in_unsigned,
    input  logic          in_word,
    input  logic [TW-1:0] in_tag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [4:0]    out_fflags,
    output logic [TW-1:0] out_tag
);

    localparam int EW   = (W == 64) ? 11 : 8;
    localparam int FW   = W - 1 - EW;
    localparam int BIAS = (1 << (EW - 1)) - 1;

    localparam logic [4:0] FLAG_NV = 5'b10000;
    localparam logic [4:0] FLAG_NX = 5'b00001;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [W-1:0]  trunc;
        logic          sign;
        logic          uns;
        logic          t32;
        logic          nan;
        logic          inf;
        logic          big;
        logic          frac;
        logic          ge_one;
        logic          nonzero;
        logic          is_min;
    } s1_t;

    function automatic logic [W-1:0] sext32(input logic [31:0] v);
        logic [W-1:0] r;
        r       = {W{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    logic          s1_valid;
    s1_t           s1;
    s1_t           cls;
    logic          s2_adv;
    logic [EW-1:0] exp_f;
    logic [FW-1:0] man_f;
    int            e;
    int            t_bits;
    logic [W-1:0]  res;
    logic [4:0]    flags;

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;

    // NOTE: every output of this block is assigned before any branch, so no latch is inferred.
    always_comb begin
        exp_f       = in_fp[W-2:FW];
        man_f       = in_fp[FW-1:0];
        e           = int'(exp_f) - BIAS;
        cls.t32     = (W == 32) || in_word;
        t_bits      = cls.t32 ? 32 : 64;
        cls.tag     = in_tag;
        cls.trunc   = in_trunc;
        cls.sign    = in_fp[W-1];
        cls.uns     = in_unsigned;
        cls.nan     = (&exp_f) && (|man_f);
        cls.inf     = (&exp_f) && !(|man_f);
        cls.big     = e >= (in_unsigned ? t_bits : t_bits - 1);
        cls.ge_one  = e >= 0;
        cls.nonzero = |in_fp[W-2:0];
        cls.is_min  = in_fp[W-1] && (e == t_bits - 1) && (man_f == '0);
        cls.frac    = 1'b0;
        // Bits of m below the binary point are the low FW-e bits for 0 <= e < FW.
        if (exp_f == '0)
            cls.frac = |man_f;
        else if (e < 0)
            cls.frac = 1'b1;
        else if (e < FW)
            cls.frac = |(man_f & ({FW{1'b1}} >> e));
    end

    always_comb begin
        res   = s1.t32 ? sext32(s1.trunc[31:0]) : s1.trunc;
        flags = {4'b0000, s1.frac};
        if (s1.nan || (!s1.sign && (s1.inf || s1.big))) begin
            res   = s1.uns ? {W{1'b1}}
                  : (s1.t32 ? sext32(32'h7FFF_FFFF) : {1'b0, {(W-1){1'b1}}});
            flags = FLAG_NV;
        end else if (!s1.uns && s1.sign && (s1.inf || s1.big)) begin
            res   = s1.t32 ? sext32(32'h8000_0000) : {1'b1, {(W-1){1'b0}}};
            flags = s1.is_min ? 5'b00000 : FLAG_NV;
        end else if (s1.uns && s1.sign && s1.ge_one) begin
            res   = '0;
            flags = FLAG_NV;
        end else if (s1.uns && s1.sign && s1.nonzero) begin
            res   = '0;
            flags = FLAG_NX;
        end
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            s1_valid <= 1'b0;
        else if (flush)
            s1_valid <= 1'b0;
        else if (in_ready)
            s1_valid <= in_valid;
    end

    // NOTE: payload registers carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready)
            s1 <= cls;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_fflags <= '0;
            out_tag    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data   <= res;
                out_fflags <= flags;
                out_tag    <= s1.tag;
            end
        end
    end

endmodule

// File: tb/tb_fcvt_int_pipe.sv
// Scoreboard bench for fcvt_int_pipe: one W=32 and one W=64 instance, a value-level
// reference model, directed corner cases, backpressure, flush and reset.
module tb_fcvt_int_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, flush, out_ready;
    logic rand_ready = 1'b0;

    logic        v32, u32, w32, rdy32, ov32;
    logic [31:0] fp32, tr32, od32;
    logic [5:0]  tag32, ot32;
    logic [4:0]  of32;

    logic        v64, u64, w64, rdy64, ov64;
    logic [63:0] fp64, tr64, od64;
    logic [5:0]  tag64, ot64;
    logic [4:0]  of64;

    fcvt_int_pipe #(.W(32), .TW(6)) dut32 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(v32), .in_ready(rdy32),
        .in_fp(fp32), .in_trunc(tr32), .in_unsigned(u32), .in_word(w32), .in_tag(tag32),
        .out_valid(ov32), .out_ready(out_ready), .out_data(od32), .out_fflags(of32),
        .out_tag(ot32)
    );

    fcvt_int_pipe #(.W(64), .TW(6)) dut64 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(v64), .in_ready(rdy64),
        .in_fp(fp64), .in_trunc(tr64), .in_unsigned(u64), .in_word(w64), .in_tag(tag64),
        .out_valid(ov64), .out_ready(out_ready), .out_data(od64), .out_fflags(of64),
        .out_tag(ot64)
    );

    typedef struct {
        logic [63:0] data;
        logic [4:0]  fl;
        logic [5:0]  tag;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic void check(input string name, input logic [63:0] got,
                                  input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, want);
    endfunction

    function automatic void fail_now(input string name);
        n_checks++;
        $display("FAIL %s: got an event that should not happen (or a timeout), expected none", name);
    endfunction

    function automatic real pow2(input int n);
        real r = 1.0;
        if (n >= 0) repeat (n) r = r * 2.0;
        else repeat (-n) r = r / 2.0;
        return r;
    endfunction

    function automatic real fp32_value(input logic [31:0] b);
        real mag;
        if (b[30:23] == 8'h00) mag = real'(b[22:0]) * pow2(-149);
        else mag = (real'(b[22:0]) + 8388608.0) * pow2(int'(b[30:23]) - 150);
        return b[31] ? -mag : mag;
    endfunction

    // Two's-complement bit pattern of an integral real with |v| < 2^64.
    function automatic logic [63:0] real_to_bits(input real v);
        real         mag, hi, lo;
        logic [63:0] b;
        mag = (v < 0.0) ? -v : v;
        hi  = $floor(mag / 4294967296.0);
        lo  = mag - hi * 4294967296.0;
        b   = {32'(longint'(hi)), 32'(longint'(lo))};
        return (v < 0.0) ? -b : b;
    endfunction

    function automatic logic [63:0] sext_word(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Value-level conversion rules; t is the target width (32 or 64).
    function automatic void ref_model(input bit nan, input bit inf, input bit s, input real x,
                                      input bit uns, input int t,
                                      output logic [63:0] res, output logic [4:0] fl);
        real lim, tv;
        lim = pow2(t - 1);
        if (nan || (!s && (inf || x >= (uns ? 2.0 * lim : lim)))) begin
            res = uns ? 64'hFFFF_FFFF_FFFF_FFFF
                : (t == 32 ? 64'h0000_0000_7FFF_FFFF : 64'h7FFF_FFFF_FFFF_FFFF);
            fl  = 5'h10;
        end else if (!uns && s && (inf || x <= -lim)) begin
            res = (t == 32) ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
            fl  = (!inf && x == -lim) ? 5'h00 : 5'h10;
        end else if (uns && s && (inf || x <= -1.0)) begin
            res = 64'h0;
            fl  = 5'h10;
        end else if (uns && x < 0.0) begin
            res = 64'h0;
            fl  = 5'h01;
        end else begin
            tv  = (x < 0.0) ? $ceil(x) : $floor(x);
            res = real_to_bits(tv);
            if (t == 32) res = sext_word(res[31:0]);
            fl  = (tv != x) ? 5'h01 : 5'h00;
        end
    endfunction

    task automatic issue(input bit sel64, input logic [63:0] fp, input logic [63:0] tr,
                         input bit uns, input bit word, input logic [5:0] tag,
                         input logic [63:0] xd, input logic [4:0] xf);
        exp_t item;
        bit   done = 1'b0;
        item.data = xd;
        item.fl   = xf;
        item.tag  = tag;
        @(negedge clk);
        if (sel64) begin
            v64 = 1'b1; fp64 = fp; tr64 = tr; u64 = uns; w64 = word; tag64 = tag;
        end else begin
            v32 = 1'b1; fp32 = fp[31:0]; tr32 = tr[31:0]; u32 = uns; tag32 = tag;
        end
        for (int i = 0; i < 300 && !done; i++) begin
            #4;
            if (sel64 ? rdy64 : rdy32) begin
                @(posedge clk);
                if (sel64) q64.push_back(item);
                else q32.push_back(item);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) fail_now(sel64 ? "issue_timeout64" : "issue_timeout32");
        #1;
        if (sel64) v64 = 1'b0;
        else v32 = 1'b0;
    endtask

    task automatic gen_op(input bit sel64, input logic [5:0] tag);
        bit          s, uns, word, nan, inf;
        int          r, t;
        logic [63:0] fp, tr, res;
        logic [4:0]  fl;
        logic [10:0] ex64;
        logic [7:0]  ex32;
        real         x, tv;
        s    = 1'($urandom_range(0, 1));
        uns  = 1'($urandom_range(0, 1));
        word = sel64 ? 1'($urandom_range(0, 1)) : 1'b0;
        r    = int'($urandom_range(0, 15));
        if (sel64) begin
            ex64 = (r == 0) ? 11'h000 : (r == 1) ? 11'h7FF
                 : (r < 4) ? 11'($urandom_range(0, 2046)) : 11'($urandom_range(1021, 1088));
            fp   = {s, ex64, ($urandom_range(0, 3) == 0) ? 52'h0 : 52'({$urandom, $urandom})};
            nan  = (ex64 == 11'h7FF) && (fp[51:0] != 52'h0);
            inf  = (ex64 == 11'h7FF) && (fp[51:0] == 52'h0);
            x    = (nan || inf) ? 0.0 : $bitstoreal(fp);
        end else begin
            ex32 = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF
                 : (r < 4) ? 8'($urandom_range(0, 254)) : 8'($urandom_range(125, 160));
            fp   = {32'h0, s, ex32, ($urandom_range(0, 3) == 0) ? 23'h0 : 23'($urandom)};
            nan  = (ex32 == 8'hFF) && (fp[22:0] != 23'h0);
            inf  = (ex32 == 8'hFF) && (fp[22:0] == 23'h0);
            x    = (nan || inf) ? 0.0 : fp32_value(fp[31:0]);
        end
        t  = (sel64 && !word) ? 64 : 32;
        tv = (x < 0.0) ? $ceil(x) : $floor(x);
        if (nan || inf || tv >= pow2(64) || tv <= -pow2(64)) tr = {$urandom, $urandom};
        else tr = real_to_bits(tv);
        ref_model(nan, inf, s, x, uns, t, res, fl);
        if (!sel64) res = {32'h0, res[31:0]};
        issue(sel64, fp, tr, uns, word, tag, res, fl);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && (q32.size() != 0 || q64.size() != 0); i++)
            @(negedge clk);
        check("drain32", 64'(q32.size()), 64'd0);
        check("drain64", 64'(q64.size()), 64'd0);
    endtask

    always @(negedge clk) if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);

    always @(negedge clk) begin
        #4;
        if (ov32 && out_ready) begin
            if (q32.size() == 0) fail_now("unexpected_out32");
            else begin : pop32
                exp_t e;
                e = q32.pop_front();
                check("data32", 64'(od32), e.data);
                check("flags32", 64'(of32), 64'(e.fl));
                check("tag32", 64'(ot32), 64'(e.tag));
            end
        end
        if (ov64 && out_ready) begin
            if (q64.size() == 0) fail_now("unexpected_out64");
            else begin : pop64
                exp_t e;
                e = q64.pop_front();
                check("data64", od64, e.data);
                check("flags64", 64'(of64), 64'(e.fl));
                check("tag64", 64'(ot64), 64'(e.tag));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        v32 = 1'b0; fp32 = '0; tr32 = '0; u32 = 1'b0; w32 = 1'b0; tag32 = '0;
        v64 = 1'b0; fp64 = '0; tr64 = '0; u64 = 1'b0; w64 = 1'b0; tag64 = '0;
        #12;
        check("rst_valid32", 64'(ov32), 64'd0);
        check("rst_data32", 64'(od32), 64'd0);
        check("rst_flags32", 64'(of32), 64'd0);
        check("rst_tag32", 64'(ot32), 64'd0);
        check("rst_valid64", 64'(ov64), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #4;
        check("rst_ready32", 64'(rdy32), 64'd1);
        check("rst_ready64", 64'(rdy64), 64'd1);

        // Directed corner cases; the first one also measures latency.
        issue(0, 64'h4049_0FDB, 64'h3, 0, 0, 6'd1, 64'h3, 5'h01);
        @(negedge clk); #4;
        check("latency_k1", 64'(ov32), 64'd0);
        @(negedge clk); #4;
        check("latency_k2", 64'(ov32), 64'd1);
        issue(0, 64'h4F00_0000, 64'h8000_0000, 0, 0, 6'd2, 64'h7FFF_FFFF, 5'h10);
        issue(0, 64'hCF00_0000, 64'h8000_0000, 0, 0, 6'd3, 64'h8000_0000, 5'h00);
        issue(0, 64'h7FC0_0000, 64'h0, 1, 0, 6'd4, 64'hFFFF_FFFF, 5'h10);
        issue(0, 64'hBF00_0000, 64'h0, 1, 0, 6'd5, 64'h0, 5'h01);
        issue(0, 64'hBF80_0000, 64'hFFFF_FFFF, 1, 0, 6'd6, 64'h0, 5'h10);
        issue(0, 64'h8000_0000, 64'h0, 0, 0, 6'd7, 64'h0, 5'h00);
        issue(1, 64'h41F0_0000_0000_0000, 64'h1_0000_0000, 1, 1, 6'd8,
              64'hFFFF_FFFF_FFFF_FFFF, 5'h10);
        issue(1, 64'h41DF_FFFF_FFC0_0000, 64'h7FFF_FFFF, 0, 1, 6'd9, 64'h7FFF_FFFF, 5'h00);
        issue(1, 64'hC3E0_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 0, 6'd10,
              64'h8000_0000_0000_0000, 5'h00);
        wait_drain(100);

        // Backpressure: two ops fill the pipe, two more wait for in_ready.
        @(negedge clk);
        out_ready = 1'b0;
        gen_op(0, 6'd11);
        gen_op(0, 6'd12);
        @(negedge clk); #4;
        check("bp_ready_low", 64'(rdy32), 64'd0);
        fork
            begin
                gen_op(0, 6'd13);
                gen_op(0, 6'd14);
            end
        join_none
        repeat (4) @(negedge clk);
        #4;
        check("bp_held_valid", 64'(ov32), 64'd1);
        check("bp_still_full", 64'(rdy32), 64'd0);
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #4;
            check("bp_no_bubble", 64'(ov32), 64'd1);
            @(negedge clk);
        end
        wait fork;
        wait_drain(100);

        // Flush with two ops in flight and a third offered in the flush cycle.
        @(negedge clk);
        out_ready = 1'b0;
        gen_op(0, 6'd20);
        gen_op(0, 6'd21);
        @(negedge clk);
        flush = 1'b1; v32 = 1'b1; fp32 = 32'h4040_0000; tr32 = 32'h3; u32 = 1'b0; tag32 = 6'd22;
        @(posedge clk);
        q32.delete();
        #1;
        flush = 1'b0; v32 = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #4;
            check("flush_empty", 64'(ov32), 64'd0);
            @(negedge clk);
        end
        issue(0, 64'h4040_0000, 64'h3, 0, 0, 6'd23, 64'h3, 5'h00);
        @(negedge clk); #4;
        check("flush_lat_k1", 64'(ov32), 64'd0);
        @(negedge clk); #4;
        check("flush_lat_k2", 64'(ov32), 64'd1);
        wait_drain(100);

        // Asynchronous reset in the middle of a stalled stream.
        @(negedge clk);
        out_ready = 1'b0;
        gen_op(0, 6'd30);
        gen_op(1, 6'd31);
        gen_op(0, 6'd32);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid32", 64'(ov32), 64'd0);
        check("arst_valid64", 64'(ov64), 64'd0);
        check("arst_data32", 64'(od32), 64'd0);
        check("arst_tag64", 64'(ot64), 64'd0);
        q32.delete();
        q64.delete();
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        #4;
        check("arst_ready32", 64'(rdy32), 64'd1);
        check("arst_ready64", 64'(rdy64), 64'd1);

        // Randomized traffic on both widths with random consumer stalls.
        rand_ready = 1'b1;
        fork
            for (int i = 0; i < 200; i++) gen_op(0, 6'(i));
            for (int j = 0; j < 200; j++) gen_op(1, 6'(j));
        join
        rand_ready = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        wait_drain(500);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
